chany_pipe_5_: RTL and testbench
================================

# chany_pipe_5_

Configurable pipeline stage on the 32-track Y-channel segment, directly upstream of switch block sb[0][5]; its output drives the switch block's `chany_bottom_in[0:31]`. Each track is independently programmed, through a configuration shift chain, to pass through combinationally, to be registered for 1 or 2 cycles, or to be tied to 0. A small load-supervision FSM counts chain shifts and gates all outputs to 0 until a complete, exact-length load has been accepted.

## Interface
- `NUM_TRACKS`, 32, number of channel tracks.
- `CFG_BITS_PER_TRACK`, 2, mode bits per track. The chain length is `CFG_LEN` = 64.
- `clk`, input, 1, single clock for both configuration and data.
- `rst_n`, input, 1. One clock; reset is synchronous and active-low.
- `config_enable`, input, 1. When high, the chain shifts one bit per cycle.
- `ccff_head`, input, 1, serial configuration data in.
- `ccff_tail`, output, 1, serial configuration data out (last chain bit).
- `chany_in`, input, [0:31], track values from the channel.
- `chany_sb_out`, output, [0:31], to `chany_bottom_in` of sb[0][5].
- `cfg_done`, output, 1, exact-length load accepted; stage active.
- `cfg_err`, output, 1, last load was short or overran.

## Operation
- Shift register `cfg[0:63]`.
  - On each cycle with `config_enable`=1: `cfg[0]<=ccff_head` and `cfg[i]<=cfg[i-1]`.
  - `ccff_tail`=`cfg[63]` (registered).
  - The first bit shifted of a 64-bit load ends in `cfg[63]`.
- Track t mode = {`cfg[2t+1]`,`cfg[2t]`}:
  - 00: bypass (`chany_sb_out[t]`=`chany_in[t]`, combinational).
  - 01: 1-cycle register.
  - 10: 2-cycle register.
  - 11: tie-off, output 0.
- Shift counter `cnt`, 7 bits, saturates at 65. A value of 65 means overrun.
- FSM states: UNCONF, SHIFTING, CONFIGURED, ERROR.
  - UNCONF/CONFIGURED/ERROR with `config_enable`=1: go to SHIFTING, `cnt`<=1, `cfg_done`<=0, `cfg_err`<=0.
  - SHIFTING with `config_enable`=1: `cnt`<=min(`cnt`+1, 65).
  - SHIFTING with `config_enable`=0: if `cnt`==64, go to CONFIGURED and set `cfg_done`<=1; otherwise go to ERROR and set `cfg_err`<=1.
- Outputs and pipeline registers:
  - In any state other than CONFIGURED, all `chany_sb_out` bits are 0, including bypass tracks.
  - In those states, both pipeline register ranks are held cleared.
  - In CONFIGURED, the pipeline registers capture `chany_in` every cycle.
- Reconfiguration mid-operation: asserting `config_enable` in CONFIGURED zeroes all outputs starting the cycle after the edge that enters SHIFTING, and flushes the pipeline registers.

## Timing
- Reset values (`rst_n`=0 at a `clk` edge):
  - `cfg`=all 0.
  - `cnt`=0, state UNCONF.
  - `cfg_done`=0, `cfg_err`=0, `ccff_tail`=0.
  - Pipeline registers 0, `chany_sb_out`=0.
- Reset overrides `config_enable` on the same edge.
- Chain latency: a bit on `ccff_head` appears on `ccff_tail` 64 shift cycles later. There is no shifting when `config_enable`=0.
- `cfg_done` and `cfg_err` rise on the edge where `config_enable` is first sampled low after SHIFTING. Outputs become live on that same edge.
- Mode 01 output at cycle n+1 equals `chany_in` at cycle n.
- Mode 10 output at cycle n+2 equals `chany_in` at cycle n.
- The first registered outputs after entering CONFIGURED are 0 for 1 cycle (mode 01) or 2 cycles (mode 10) while the ranks fill from the cleared state.
- Bypass tracks have zero latency once `cfg_done`=1.
- `config_enable` pulses of length 0 are impossible. A single-cycle pulse gives `cnt`=1, which leads to ERROR.

## Test plan
- Reset, then drive `chany_in`=32'hFFFFFFFF with no load.
  - Required: `chany_sb_out`=0, `cfg_done`=0, `cfg_err`=0, `ccff_tail`=0.
- Load 64 bits giving all tracks mode 00, then drive `chany_in`=32'hA5A5A5A5.
  - Required: `cfg_done`=1 on the edge after `config_enable` drops.
  - Required: `chany_sb_out`=32'hA5A5A5A5 in the same cycle as the input.
- Load tracks 0–7 as 01, 8–15 as 10, 16–23 as 11, 24–31 as 00.
  - Stimulus: drive `chany_in`=32'hFFFFFFFF for 1 cycle, then 0.
  - Required: one-cycle pulses, with bits 0–7 one cycle late and bits 8–15 two cycles late.
  - Required: bits 16–23 always 0; bits 24–31 follow the input with zero latency.
- Short load of 63 shifts.
  - Required: `cfg_err`=1, `cfg_done`=0, outputs 0.
- Overrun load of 66 shifts.
  - Required: `cfg_err`=1.
  - Required: `ccff_tail` outputs the head bits delayed by 64 cycles.
  - Required: an immediate reload of exactly 64 shifts clears `cfg_err` and sets `cfg_done`.
- While CONFIGURED with mode-10 tracks carrying data, assert `config_enable` or pull `rst_n` low for 1 cycle.
  - Required: outputs go to 0 and pipeline contents are flushed.
  - Required: after reset, the state is UNCONF and `cfg` is all 0.

Source files
------------

// File: rtl/chany_pipe_5__if.sv
// Channel-side bundle for the chany_pipe_5_ stage: config chain, track data
// and load status.
interface chany_pipe_5__if #(
  parameter int NUM_TRACKS = 32
);
  logic                    config_enable;
  logic                    ccff_head;
  logic                    ccff_tail;
  logic [0:NUM_TRACKS-1]   chany_in;
  logic [0:NUM_TRACKS-1]   chany_sb_out;
  logic                    cfg_done;
  logic                    cfg_err;

  modport master (
    output config_enable, ccff_head, chany_in,
    input  ccff_tail, chany_sb_out, cfg_done, cfg_err
  );

  modport slave (
    input  config_enable, ccff_head, chany_in,
    output ccff_tail, chany_sb_out, cfg_done, cfg_err
  );
endinterface

// File: rtl/chany_pipe_5_.sv
// Per-track configurable pipeline stage feeding chany_bottom_in of sb[0][5],
// with a shift-chain load supervisor that gates outputs until a clean load.
module chany_pipe_5_ #(
  parameter int NUM_TRACKS         = 32,
  parameter int CFG_BITS_PER_TRACK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  chany_pipe_5__if.slave   bus
);
  localparam int CFG_LEN = NUM_TRACKS * CFG_BITS_PER_TRACK;
  localparam logic [6:0] CNT_FULL = 7'(CFG_LEN);
  localparam logic [6:0] CNT_SAT  = 7'(CFG_LEN + 1);

  typedef enum logic [1:0] {UNCONF, SHIFTING, CONFIGURED, ERROR} state_t;

  state_t                state;
  logic [0:CFG_LEN-1]    cfg;
  logic [6:0]            cnt;
  logic                  done_reg;
  logic                  err_reg;
  logic [0:NUM_TRACKS-1] rank1;
  logic [0:NUM_TRACKS-1] rank2;
  logic [0:NUM_TRACKS-1] sb_out;
  logic                  live;

  assign live = (state == CONFIGURED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= UNCONF;
      cfg      <= '0;
      cnt      <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      rank1    <= '0;
      rank2    <= '0;
    end else begin
      if (bus.config_enable) begin
        cfg <= {bus.ccff_head, cfg[0:CFG_LEN-2]};
      end

      case (state)
        SHIFTING: begin
          if (bus.config_enable) begin
            cnt <= (cnt >= CNT_SAT) ? CNT_SAT : cnt + 7'd1;
          end else if (cnt == CNT_FULL) begin
            state    <= CONFIGURED;
            done_reg <= 1'b1;
          end else begin
            state   <= ERROR;
            err_reg <= 1'b1;
          end
        end
        default: begin
          if (bus.config_enable) begin
            state    <= SHIFTING;
            cnt      <= 7'd1;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
          end
        end
      endcase

      // Ranks run only while live; a reload request flushes them on the same edge.
      if (live && !bus.config_enable) begin
        rank1 <= bus.chany_in;
        rank2 <= rank1;
      end else begin
        rank1 <= '0;
        rank2 <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_track
    logic [1:0] mode;
    assign mode = {cfg[2*gi+1], cfg[2*gi]};
    assign sb_out[gi] = live & ((mode == 2'b00) ? bus.chany_in[gi] :
                                (mode == 2'b01) ? rank1[gi] :
                                (mode == 2'b10) ? rank2[gi] : 1'b0);
  end

  assign bus.chany_sb_out = sb_out;
  assign bus.ccff_tail    = cfg[CFG_LEN-1];
  assign bus.cfg_done     = done_reg;
  assign bus.cfg_err      = err_reg;
endmodule

// File: tb/tb_chany_pipe_5_.sv
// Bench for chany_pipe_5_: behavioural model of load rules and per-track
// delays, table vectors for mixed modes, and directed/random load sequences.
module tb_chany_pipe_5_;
  logic clk;
  logic rst_n;
  chany_pipe_5__if bus();

  chany_pipe_5_ dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: shifted-bit history (index 0 = most recent), load run tracking,
  // and the last two inputs seen while the stage was live.
  bit         hist[$];
  bit         m_live = 0, m_err = 0, m_inrun = 0;
  int         m_run = 0;
  logic [0:31] h1 = '0, h2 = '0;
  logic [0:31] last_out;

  typedef struct {
    logic [0:31] din;
    logic [0:31] exp;
  } vec_t;
  vec_t tbl[6];

  function automatic bit cfg_bit(input int i);
    return (i < hist.size()) ? hist[i] : 1'b0;
  endfunction

  function automatic logic [0:31] model_out(input logic [0:31] d);
    logic [0:31] o;
    o = '0;
    if (m_live) begin
      for (int t = 0; t < 32; t++) begin
        case ({cfg_bit(2*t+1), cfg_bit(2*t)})
          2'b00: o[t] = d[t];
          2'b01: o[t] = h1[t];
          2'b10: o[t] = h2[t];
          default: o[t] = 1'b0;
        endcase
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ce, input logic hd, input logic [0:31] d);
    rst_n = r;
    bus.config_enable = ce;
    bus.ccff_head = hd;
    bus.chany_in = d;
    #1;
    last_out = bus.chany_sb_out;
    chk("sb_out", bus.chany_sb_out, model_out(d));
    chk("cfg_done", {31'd0, bus.cfg_done}, {31'd0, m_live});
    chk("cfg_err", {31'd0, bus.cfg_err}, {31'd0, m_err});
    chk("ccff_tail", {31'd0, bus.ccff_tail}, {31'd0, cfg_bit(63)});
    @(posedge clk);
    if (!r) begin
      hist.delete();
      m_live = 0; m_err = 0; m_inrun = 0; m_run = 0;
      h1 = '0; h2 = '0;
    end else begin
      if (m_live && !ce) begin
        h2 = h1;
        h1 = d;
      end else begin
        h1 = '0;
        h2 = '0;
      end
      if (ce) begin
        hist.push_front(hd);
        if (hist.size() > 64) void'(hist.pop_back());
        if (!m_inrun) begin
          m_inrun = 1; m_run = 1; m_live = 0; m_err = 0;
        end else begin
          m_run++;
        end
      end else if (m_inrun) begin
        m_inrun = 0;
        m_live = (m_run == 64);
        m_err = !m_live;
      end
    end
    @(negedge clk);
  endtask

  // Shift n bits (cfg word for exact loads, random otherwise), then one idle cycle.
  task automatic load(input logic [0:63] w, input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b1, (n == 64) ? w[63-k] : 1'($urandom), $urandom);
    end
    step(1'b1, 1'b0, 1'b0, $urandom);
  endtask

  function automatic logic [0:63] uniform_cfg(input logic [1:0] m);
    logic [0:63] c;
    for (int t = 0; t < 32; t++) begin
      c[2*t+1] = m[1];
      c[2*t]   = m[0];
    end
    return c;
  endfunction

  initial begin
    logic [0:63] c;
    logic [1:0]  m;
    clk = 0;
    rst_n = 0;
    bus.config_enable = 0;
    bus.ccff_head = 0;
    bus.chany_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Unconfigured: everything held at 0.
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);

    // All-bypass load: input appears in the same cycle.
    load(uniform_cfg(2'b00), 64);
    step(1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
    chk("bypass_a5", last_out, 32'hA5A5A5A5);

    // Mixed modes: 0-7 one cycle, 8-15 two cycles, 16-23 tied, 24-31 bypass.
    for (int t = 0; t < 32; t++) begin
      m = (t < 8) ? 2'b01 : (t < 16) ? 2'b10 : (t < 24) ? 2'b11 : 2'b00;
      c[2*t+1] = m[1];
      c[2*t]   = m[0];
    end
    tbl[0] = '{32'h00000000, 32'h00000000};
    tbl[1] = '{32'h00000000, 32'h00000000};
    tbl[2] = '{32'hFFFFFFFF, 32'h000000FF};
    tbl[3] = '{32'h00000000, 32'hFF000000};
    tbl[4] = '{32'h00000000, 32'h00FF0000};
    tbl[5] = '{32'h00000000, 32'h00000000};
    load(c, 64);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, tbl[i].din);
      chk($sformatf("mixed_vec%0d", i), last_out, tbl[i].exp);
    end

    // Short load -> error, outputs 0.
    load(uniform_cfg(2'b00), 63);
    step(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    chk("short_err", {31'd0, bus.cfg_err}, 32'd1);

    // Overrun, then an immediate exact reload recovers.
    load(uniform_cfg(2'b00), 66);
    chk("overrun_err", {31'd0, bus.cfg_err}, 32'd1);
    load(uniform_cfg(2'b01), 64);
    chk("reload_done", {31'd0, bus.cfg_done}, 32'd1);
    repeat (4) step(1'b1, 1'b0, 1'b0, $urandom);

    // Mode-10 data interrupted by a one-cycle config pulse.
    load(uniform_cfg(2'b10), 64);
    repeat (5) step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b1, 1'b1, 1'b1, $urandom);
    repeat (3) step(1'b1, 1'b0, 1'b0, $urandom);
    chk("pulse_zero", last_out, 32'h0);

    // Mode-10 data interrupted by reset; then shifting ones shows cfg was cleared.
    load(uniform_cfg(2'b10), 64);
    repeat (5) step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, $urandom);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
    chk("reset_zero", last_out, 32'h0);
    for (int k = 0; k < 64; k++) step(1'b1, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b0, 1'b0, $urandom);

    // Random loads of random length and random data.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 64; i++) c[i] = 1'($urandom);
      load(c, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 70)) : 64);
      repeat (20) step(1'b1, 1'b0, 1'b0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
